kfpga_config_loader: RTL and testbench

//  Bitstream loader directly upstream of the kFPGA core configuration chain.
//  - Accepts WORD_WIDTH-bit words from a host over a valid/ready handshake.
//  - Clears the chain, then serialises the words LSB-first onto the core's serial config input.
//  - Stops after exactly CHAIN_LENGTH shifts and reports done/error to the host.

---
 rtl/kfpga_config_loader.sv | 275 +++++++++++++++++++++++++++
 tb/tb_kfpga_config_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/kfpga_config_loader.sv
// ---------------------------------------------------------------------------
// kfpga_config_loader
//
// Bitstream loader that sits directly in front of the kFPGA core
// configuration chain. A host streams WORD_WIDTH-bit words over a
// valid/ready handshake. A load clears the chain first, then shifts the
// words out LSB-first, one bit per config_enable cycle. It stops after
// exactly CHAIN_LENGTH shifts and then reports done.
//
// Optional feature (compile-time macro KFPGA_CFG_CHECKSUM_EN):
//   After the last data shift, the loader accepts one extra checksum word.
//   This word is never shifted. It is compared with the running sum
//   (mod 2**WORD_WIDTH) of all accepted data words, and a mismatch sets
//   the sticky error flag. Without the macro there is no checksum word and
//   error stays 0.
//
// Ports
//   clock          in   1           single clock, rising edge
//   nreset         in   1           asynchronous active-low reset
//   start          in   1           1-cycle pulse; begins a load when idle/done
//   word_data      in   WORD_WIDTH  bitstream word; bit 0 is shifted first
//   word_valid     in   1           word_data valid
//   word_ready     out  1           loader accepts word this cycle
//   config_in      out  1           serial bit to the core config chain
//   config_enable  out  1           chain shift enable, one bit per high cycle
//   config_nreset  out  1           active-low chain clear
//   busy           out  1           load in progress
//   done           out  1           sticky; load complete
//   error          out  1           sticky; checksum mismatch
// ---------------------------------------------------------------------------
module kfpga_config_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 2048,
  parameter int CNT_WIDTH    = 16,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_in,
  output logic                  config_enable,
  output logic                  config_nreset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // Width of the "bits left in shifter" counter (must hold WORD_WIDTH).
  localparam int LEFT_W = $clog2(WORD_WIDTH + 1);
  // Width of the clear-phase cycle counter.
  localparam int CLR_W  = $clog2(CLEAR_CYCLES + 1);

  localparam logic [CNT_WIDTH-1:0] CHAIN_LEN_C  = CNT_WIDTH'(CHAIN_LENGTH);
  localparam logic [CNT_WIDTH-1:0] WORD_LEN_C   = CNT_WIDTH'(WORD_WIDTH);
  localparam logic [LEFT_W-1:0]    WORD_BITS_C  = LEFT_W'(WORD_WIDTH);
  localparam logic [CLR_W-1:0]     CLEAR_LAST_C = CLR_W'(CLEAR_CYCLES - 1);

`ifdef KFPGA_CFG_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Checksum accumulation: plain modular sum of full words.
  function automatic logic [WORD_WIDTH-1:0] checksum_add(
    input logic [WORD_WIDTH-1:0] acc,
    input logic [WORD_WIDTH-1:0] word
  );
    return acc + word;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DONE  = 3'd4
  } state_t;
`endif

  state_t                state_r, state_s;
  logic [CLR_W-1:0]      clear_cnt_r, clear_cnt_s;
  logic [CNT_WIDTH-1:0]  bit_cnt_r, bit_cnt_s;
  logic [WORD_WIDTH-1:0] shifter_r, shifter_s;
  logic [LEFT_W-1:0]     left_r, left_s;
  logic                  cfg_in_r, cfg_in_s;
  logic                  cfg_en_r, cfg_en_s;
  logic                  cfg_nrst_r, cfg_nrst_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  error_r, error_s;
  logic                  word_ready_s;
  logic                  accept_s;
  logic [CNT_WIDTH-1:0]  remaining_s;
  logic [LEFT_W-1:0]     load_bits_s;
`ifdef KFPGA_CFG_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] sum_r, sum_s;
`endif

  // Ready decode: depends only on registered state so the host sees a clean signal.
  always_comb begin
    word_ready_s = 1'b0;
    case (state_r)
      // Stop asking for words once the whole chain has been covered.
      ST_LOAD:  word_ready_s = (left_r == {LEFT_W{1'b0}}) && (bit_cnt_r != CHAIN_LEN_C);
`ifdef KFPGA_CFG_CHECKSUM_EN
      ST_CHECK: word_ready_s = 1'b1;
`endif
      default:  word_ready_s = 1'b0;
    endcase
  end

  assign accept_s = word_ready_s & word_valid;

  // Bits to take from the next word; the last word may be only partly used.
  always_comb begin
    remaining_s = CHAIN_LEN_C - bit_cnt_r;
    if (remaining_s >= WORD_LEN_C) begin
      load_bits_s = WORD_BITS_C;
    end else begin
      load_bits_s = remaining_s[LEFT_W-1:0];
    end
  end

  // Next-state and next-output logic for the load sequencer.
  always_comb begin
    state_s     = state_r;
    clear_cnt_s = clear_cnt_r;
    bit_cnt_s   = bit_cnt_r;
    shifter_s   = shifter_r;
    left_s      = left_r;
    cfg_in_s    = 1'b0;
    cfg_en_s    = 1'b0;
    cfg_nrst_s  = 1'b1;
    error_s     = error_r;
`ifdef KFPGA_CFG_CHECKSUM_EN
    sum_s       = sum_r;
`endif

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // A new load drops the previous result and starts clearing the chain.
          state_s     = ST_CLEAR;
          clear_cnt_s = {CLR_W{1'b0}};
          bit_cnt_s   = {CNT_WIDTH{1'b0}};
          left_s      = {LEFT_W{1'b0}};
          cfg_nrst_s  = 1'b0;
          error_s     = 1'b0;
`ifdef KFPGA_CFG_CHECKSUM_EN
          sum_s       = {WORD_WIDTH{1'b0}};
`endif
        end else begin
          state_s = state_r;
        end
      end

      ST_CLEAR: begin
        if (clear_cnt_r == CLEAR_LAST_C) begin
          state_s   = ST_LOAD;
          bit_cnt_s = {CNT_WIDTH{1'b0}};
        end else begin
          clear_cnt_s = clear_cnt_r + CLR_W'(1'b1);
          cfg_nrst_s  = 1'b0;
        end
      end

      ST_LOAD: begin
        if (left_r != {LEFT_W{1'b0}}) begin
          // Shift one bit out. config_enable is registered, so it lines up
          // with the bit on config_in in the same output cycle.
          cfg_en_s  = 1'b1;
          cfg_in_s  = shifter_r[0];
          shifter_s = shifter_r >> 1;
          left_s    = left_r - LEFT_W'(1'b1);
          bit_cnt_s = bit_cnt_r + CNT_WIDTH'(1'b1);
        end else if (bit_cnt_r == CHAIN_LEN_C) begin
`ifdef KFPGA_CFG_CHECKSUM_EN
          state_s = ST_CHECK;
`else
          state_s = ST_DONE;
`endif
        end else if (accept_s) begin
          // Accept cycle is the one-cycle bubble; surplus upper bits stay unshifted.
          shifter_s = word_data;
          left_s    = load_bits_s;
`ifdef KFPGA_CFG_CHECKSUM_EN
          sum_s     = checksum_add(sum_r, word_data);
`endif
        end else begin
          // Host stall: chain holds, nothing shifts.
          state_s = state_r;
        end
      end

`ifdef KFPGA_CFG_CHECKSUM_EN
      ST_CHECK: begin
        if (accept_s) begin
          error_s = (word_data != sum_r);
          state_s = ST_DONE;
        end else begin
          state_s = state_r;
        end
      end
`endif

      default: begin
        // Unreachable encoding: recover to a safe idle state.
        state_s = ST_IDLE;
      end
    endcase

`ifndef KFPGA_CFG_CHECKSUM_EN
    error_s = 1'b0;
`endif

    // Status outputs follow the state being entered, so they are registered
    // yet aligned with the state.
    busy_s = (state_s == ST_CLEAR) || (state_s == ST_LOAD)
`ifdef KFPGA_CFG_CHECKSUM_EN
             || (state_s == ST_CHECK)
`endif
             ;
    done_s = (state_s == ST_DONE);
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_r     <= ST_IDLE;
      clear_cnt_r <= {CLR_W{1'b0}};
      bit_cnt_r   <= {CNT_WIDTH{1'b0}};
      shifter_r   <= {WORD_WIDTH{1'b0}};
      left_r      <= {LEFT_W{1'b0}};
      cfg_in_r    <= 1'b0;
      cfg_en_r    <= 1'b0;
      cfg_nrst_r  <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
`ifdef KFPGA_CFG_CHECKSUM_EN
      sum_r       <= {WORD_WIDTH{1'b0}};
`endif
    end else begin
      state_r     <= state_s;
      clear_cnt_r <= clear_cnt_s;
      bit_cnt_r   <= bit_cnt_s;
      shifter_r   <= shifter_s;
      left_r      <= left_s;
      cfg_in_r    <= cfg_in_s;
      cfg_en_r    <= cfg_en_s;
      cfg_nrst_r  <= cfg_nrst_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      error_r     <= error_s;
`ifdef KFPGA_CFG_CHECKSUM_EN
      sum_r       <= sum_s;
`endif
    end
  end

  assign word_ready    = word_ready_s;
  assign config_in     = cfg_in_r;
  assign config_enable = cfg_en_r;
  assign config_nreset = cfg_nrst_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;

endmodule

// File: tb/tb_kfpga_config_loader.sv
// ---------------------------------------------------------------------------
// tb_kfpga_config_loader
//
// Table-driven bench for kfpga_config_loader with CHAIN_LENGTH=20,
// WORD_WIDTH=8 and CLEAR_CYCLES=2. Each table row holds three data words,
// a checksum word, the host gap, and the hand-computed 20-bit chain image
// (bit i = i-th config_in bit). Hand-written sequences cover the reset
// values and a reset in the middle of a load.
// ---------------------------------------------------------------------------
module tb_kfpga_config_loader;

  logic       clock = 1'b0;
  logic       nreset;
  logic       start;
  logic [7:0] word_data;
  logic       word_valid;
  logic       word_ready;
  logic       config_in;
  logic       config_enable;
  logic       config_nreset;
  logic       busy;
  logic       done;
  logic       error;

  kfpga_config_loader #(
    .WORD_WIDTH(8),
    .CHAIN_LENGTH(20),
    .CNT_WIDTH(16),
    .CLEAR_CYCLES(2)
  ) dut (
    .clock(clock),
    .nreset(nreset),
    .start(start),
    .word_data(word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .config_in(config_in),
    .config_enable(config_enable),
    .config_nreset(config_nreset),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: statistics of one load, cleared when an accepted start is seen.
  int          cyc        = 0;
  int          pulses     = 0;
  int          accepts    = 0;
  int          nlow       = 0;
  int          first_low  = -1;
  int          last_low   = -1;
  int          first_en   = -1;
  int          last_en    = -1;
  int          overlap    = 0;
  int          stall_viol = 0;
  logic [63:0] stream     = 64'd0;
  logic        prev_stall = 1'b0;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (start && !busy && nreset) begin
      pulses = 0; accepts = 0; nlow = 0;
      first_low = -1; last_low = -1; first_en = -1; last_en = -1;
      overlap = 0; stall_viol = 0; stream = 64'd0; prev_stall = 1'b0;
    end else begin
      if (config_enable) begin
        if (pulses < 64) stream[pulses] = config_in;
        pulses = pulses + 1;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        if (prev_stall) stall_viol = stall_viol + 1;
        if (!config_nreset) overlap = overlap + 1;
      end
      if (!config_nreset) begin
        nlow = nlow + 1;
        if (first_low < 0) first_low = cyc;
        last_low = cyc;
      end
      if (word_valid && word_ready) accepts = accepts + 1;
      prev_stall = word_ready && !word_valid;
    end
  end

  typedef struct {
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [7:0]  w2;
    logic [7:0]  csum;
    int          gap;
    logic        mid_start;
    logic [19:0] exp_stream;
    int          exp_span;   // 0 = span not checked for this row
    logic        exp_err;    // only meaningful with the checksum macro
  } vec_t;

  vec_t tbl [8];

`ifdef KFPGA_CFG_CHECKSUM_EN
  localparam int EXP_ACCEPTS = 4;
`else
  localparam int EXP_ACCEPTS = 3;
`endif

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"},  {31'd0, word_ready},    32'd0);
    chk({tag, "_cin"},    {31'd0, config_in},     32'd0);
    chk({tag, "_cen"},    {31'd0, config_enable}, 32'd0);
    chk({tag, "_cnrst"},  {31'd0, config_nreset}, 32'd1);
    chk({tag, "_busy"},   {31'd0, busy},          32'd0);
    chk({tag, "_done"},   {31'd0, done},          32'd0);
    chk({tag, "_error"},  {31'd0, error},         32'd0);
  endtask

  // Host driver plus result checks for one full load. Called at posedge+1.
  task automatic run_load(input vec_t v, input int idx);
    logic [7:0] words [4];
    logic       got;
    logic       exp_err;
    string      t;
    t = $sformatf("v%0d", idx);
    words[0] = v.w0; words[1] = v.w1; words[2] = v.w2; words[3] = v.csum;
`ifdef KFPGA_CFG_CHECKSUM_EN
    exp_err = v.exp_err;
`else
    exp_err = 1'b0;
`endif
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk({t, "_start_done"},  {31'd0, done},          32'd0);
    chk({t, "_start_busy"},  {31'd0, busy},          32'd1);
    chk({t, "_start_cnrst"}, {31'd0, config_nreset}, 32'd0);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      word_data  = words[i];
      word_valid = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 200 && !got && !done; c++) begin
        @(negedge clock);
        if (word_ready) got = 1'b1;
      end
      if (!got && !done) chk({t, "_ready_timeout"}, 32'd0, 32'd1);
      @(posedge clock); #1;
      word_valid = 1'b0;
      if (v.mid_start && i == 0) begin
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
      end
      for (int g = 0; g < v.gap; g++) begin
        @(posedge clock); #1;
      end
      if (!got) break;
    end
    for (int c = 0; c < 200 && !done; c++) @(negedge clock);
    if (!done) chk({t, "_done_timeout"}, 32'd0, 32'd1);
    @(negedge clock);
    chk({t, "_stream"},  {12'd0, stream[19:0]}, {12'd0, v.exp_stream});
    chk({t, "_pulses"},  pulses,  32'd20);
    chk({t, "_accepts"}, accepts, EXP_ACCEPTS);
    chk({t, "_done"},    {31'd0, done},  32'd1);
    chk({t, "_busy"},    {31'd0, busy},  32'd0);
    chk({t, "_error"},   {31'd0, error}, {31'd0, exp_err});
    chk({t, "_clr_len"}, nlow, 32'd2);
    chk({t, "_clr_run"}, last_low - first_low + 1, 32'd2);
    chk({t, "_en_after_clr"}, {31'd0, (first_en >= last_low + 2)}, 32'd1);
    chk({t, "_overlap"}, overlap, 32'd0);
    chk({t, "_stall"},   stall_viol, 32'd0);
    if (v.exp_span != 0) chk({t, "_span"}, last_en - first_en + 1, v.exp_span);
    @(posedge clock); #1;
  endtask

  initial begin
    // w0, w1, w2, csum, gap, mid_start, chain image {w2[3:0],w1,w0}, span, err
    tbl[0] = '{8'hA5, 8'h3C, 8'hFF, 8'hE0, 0,  1'b0, 20'hF3CA5, 22, 1'b0};
    tbl[1] = '{8'hA5, 8'h3C, 8'hFF, 8'hE0, 10, 1'b0, 20'hF3CA5, 0,  1'b0};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 0,  1'b0, 20'h00000, 22, 1'b0};
    tbl[3] = '{8'h01, 8'h80, 8'h0F, 8'h90, 0,  1'b0, 20'hF8001, 22, 1'b0};
    tbl[4] = '{8'h12, 8'h34, 8'h56, 8'h9C, 0,  1'b1, 20'h63412, 0,  1'b0};
    tbl[5] = '{8'hFF, 8'h00, 8'hA0, 8'h9F, 3,  1'b0, 20'h000FF, 0,  1'b0};
    tbl[6] = '{8'h01, 8'h02, 8'h03, 8'h06, 0,  1'b0, 20'h30201, 22, 1'b0};
    tbl[7] = '{8'h01, 8'h02, 8'h03, 8'h07, 0,  1'b0, 20'h30201, 22, 1'b1};

    nreset     = 1'b0;
    start      = 1'b0;
    word_data  = 8'h00;
    word_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values("rst");
    @(posedge clock); #1;
    nreset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 8; i++) begin
      run_load(tbl[i], i);
    end

    // Reset after 9 shifted bits: outputs return to reset values at once.
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    word_data  = 8'hA5;
    word_valid = 1'b1;
    for (int c = 0; c < 200 && pulses < 9; c++) @(negedge clock);
    chk("midrst_pulses", pulses, 32'd9);
    nreset = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clock); #1;
    word_valid = 1'b0;
    nreset = 1'b1;
    @(posedge clock); #1;
    run_load(tbl[0], 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
